// File: rtl/filter_line_scheduler.sv
// rtl/filter_line_scheduler.sv - row rotation and window sequencing for the 3-row line-buffer filter
//
// Purpose:
//   Accepts a pixel stream and writes each row into one of three rotating line
//   buffers. Once three rows are held, it sweeps the middle row and emits a window
//   strobe delayed by the RAM read latency. It also tracks rows per frame and
//   handles frame abort and restart.
//
// Optional feature macro: FILTER_SCHED_BORDER_PASS_EN
//   defined   - sweeps cover columns 0..BLOCK_LENGTH-1; win_border flags the edge columns
//   undefined - sweeps cover columns 1..BLOCK_LENGTH-2; win_border is tied 0
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   frame_start           pulse: start or restart a frame
//   pix_valid/pix_data    pixel source; pix_ready accepts the pixel this cycle
//   wren/wr_row/wr_data   line-buffer write (one-hot buffer, registered data)
//   cursor                column address, aligned with wren and rd_en
//   rd_en/top_sel         read-sweep strobe, physical index of the oldest row
//   out_ready             filter core can take a new window
//   win_valid/win_cursor  window valid at the buffer outputs, and its column
//   win_border            window column is 0 or BLOCK_LENGTH-1
//   frame_done            pulse after the last window of a frame
module filter_line_scheduler #(
  parameter int BLOCK_LENGTH = 720,
  parameter int FRAME_ROWS   = 480,
  parameter int RAM_LATENCY  = 3,
  parameter int CURSOR_W     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                pix_valid,
  input  logic [15:0]         pix_data,
  output logic                pix_ready,
  output logic                wren,
  output logic [2:0]          wr_row,
  output logic [15:0]         wr_data,
  output logic [CURSOR_W-1:0] cursor,
  output logic                rd_en,
  output logic [1:0]          top_sel,
  input  logic                out_ready,
  output logic                win_valid,
  output logic [CURSOR_W-1:0] win_cursor,
  output logic                win_border,
  output logic                frame_done
);

  localparam int ROW_W = $clog2(FRAME_ROWS + 1);

  localparam logic [CURSOR_W-1:0] LAST_COL      = CURSOR_W'(BLOCK_LENGTH - 1);
`ifdef FILTER_SCHED_BORDER_PASS_EN
  localparam logic [CURSOR_W-1:0] SWEEP_FIRST   = '0;
  localparam logic [CURSOR_W-1:0] SWEEP_LAST    = CURSOR_W'(BLOCK_LENGTH - 1);
`else
  localparam logic [CURSOR_W-1:0] SWEEP_FIRST   = CURSOR_W'(1);
  localparam logic [CURSOR_W-1:0] SWEEP_LAST    = CURSOR_W'(BLOCK_LENGTH - 2);
`endif
  localparam logic [ROW_W-1:0]    ROWS_DONE     = ROW_W'(FRAME_ROWS);
  localparam logic [ROW_W-1:0]    ROWS_TO_SWEEP = ROW_W'(3);

  typedef enum logic [1:0] {IDLE, FILL, SWEEP, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  // col_q is the next column to write or issue; cursor_q is the column that
  // goes with the wren/rd_en pulse currently on the outputs.
  logic [CURSOR_W-1:0]   col_q, col_d;
  logic [CURSOR_W-1:0]   cursor_q, cursor_d;
  logic                  wren_q, wren_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic [2:0]            wr_row_q, wr_row_d;
  logic                  rd_en_q, rd_en_d;
  logic [1:0]            top_sel_q, top_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  pix_ready_q, pix_ready_d;
  logic [RAM_LATENCY-1:0] pv_q, pv_d;
  logic [CURSOR_W-1:0]   pc_q [RAM_LATENCY];
  logic [CURSOR_W-1:0]   pc_d [RAM_LATENCY];

  logic             handshake;
  logic             pipe_empty;
  logic [ROW_W-1:0] row_cnt_inc;

  // The oldest row sits in the buffer after the one just written.
  function automatic logic [1:0] next_top(input logic [2:0] row);
    case (row)
      3'b001:  next_top = 2'd1;
      3'b010:  next_top = 2'd2;
      default: next_top = 2'd0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_d        = col_q;
    cursor_d     = cursor_q;
    wren_d       = 1'b0;
    wr_data_d    = wr_data_q;
    wr_row_d     = wr_row_q;
    rd_en_d      = 1'b0;
    top_sel_d    = top_sel_q;
    frame_done_d = 1'b0;

    handshake   = pix_ready_q && pix_valid && !frame_start;
    pipe_empty  = !rd_en_q && (pv_q == '0);
    row_cnt_inc = row_cnt_q + ROW_W'(1);

    // Read-latency pipeline always advances; out_ready never stalls it.
    pv_d[0] = rd_en_q;
    pc_d[0] = cursor_q;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
    end

    // Rotate one cycle after the last column's write is on the outputs, so
    // wr_row stays aligned with every wren pulse of its row.
    if (wren_q && (cursor_q == LAST_COL)) begin
      wr_row_d = {wr_row_q[1:0], wr_row_q[2]};
    end

    if (frame_start) begin
      state_d   = FILL;
      row_cnt_d = '0;
      col_d     = '0;
      cursor_d  = '0;
      wr_row_d  = 3'b001;
      pv_d      = '0;
    end else begin
      case (state_q)
        IDLE: ;
        FILL: begin
          if (handshake) begin
            wren_d    = 1'b1;
            wr_data_d = pix_data;
            cursor_d  = col_q;
            if (col_q == LAST_COL) begin
              col_d     = '0;
              row_cnt_d = row_cnt_inc;
              if (row_cnt_inc >= ROWS_TO_SWEEP) begin
                state_d   = SWEEP;
                col_d     = SWEEP_FIRST;
                top_sel_d = next_top(wr_row_q);
              end
            end else begin
              col_d = col_q + CURSOR_W'(1);
            end
          end
        end
        SWEEP: begin
          if (out_ready) begin
            rd_en_d  = 1'b1;
            cursor_d = col_q;
            col_d    = col_q + CURSOR_W'(1);
            if (col_q == SWEEP_LAST) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            col_d    = '0;
            cursor_d = '0;
            if (row_cnt_q == ROWS_DONE) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = FILL;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pix_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      col_q        <= '0;
      cursor_q     <= '0;
      wren_q       <= 1'b0;
      wr_data_q    <= '0;
      wr_row_q     <= 3'b001;
      rd_en_q      <= 1'b0;
      top_sel_q    <= '0;
      frame_done_q <= 1'b0;
      pix_ready_q  <= 1'b0;
      pv_q         <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_q        <= col_d;
      cursor_q     <= cursor_d;
      wren_q       <= wren_d;
      wr_data_q    <= wr_data_d;
      wr_row_q     <= wr_row_d;
      rd_en_q      <= rd_en_d;
      top_sel_q    <= top_sel_d;
      frame_done_q <= frame_done_d;
      pix_ready_q  <= pix_ready_d;
      pv_q         <= pv_d;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign pix_ready  = pix_ready_q;
  assign wren       = wren_q;
  assign wr_row     = wr_row_q;
  assign wr_data    = wr_data_q;
  assign cursor     = cursor_q;
  assign rd_en      = rd_en_q;
  assign top_sel    = top_sel_q;
  assign win_valid  = pv_q[RAM_LATENCY-1];
  assign win_cursor = pc_q[RAM_LATENCY-1];
  assign frame_done = frame_done_q;

`ifdef FILTER_SCHED_BORDER_PASS_EN
  assign win_border = win_valid && ((win_cursor == '0) || (win_cursor == LAST_COL));
`else
  assign win_border = 1'b0;
`endif

endmodule

// File: tb/tb_filter_line_scheduler.sv
// tb/tb_filter_line_scheduler.sv - directed self-checking bench for filter_line_scheduler
module tb_filter_line_scheduler;

  localparam int BL = 8;
  localparam int FR = 5;
  localparam int RL = 3;
  localparam int CW = 4;
`ifdef FILTER_SCHED_BORDER_PASS_EN
  localparam int FIRST_C = 0;
  localparam int WPR     = 8;
  localparam bit BORDER  = 1'b1;
`else
  localparam int FIRST_C = 1;
  localparam int WPR     = 6;
  localparam bit BORDER  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic          pix_ready;
  logic          wren;
  logic [2:0]    wr_row;
  logic [15:0]   wr_data;
  logic [CW-1:0] cursor;
  logic          rd_en;
  logic [1:0]    top_sel;
  logic          out_ready;
  logic          win_valid;
  logic [CW-1:0] win_cursor;
  logic          win_border;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int wr_rows[$];
  int wr_curs[$];
  int wr_datas[$];
  int wr_cyc[$];
  int rd_curs[$];
  int rd_cyc[$];
  int rd_top[$];
  int win_curs[$];
  int win_cyc[$];
  int win_bord[$];
  int done_cnt;
  int done_cyc;

  filter_line_scheduler #(
    .BLOCK_LENGTH(BL), .FRAME_ROWS(FR), .RAM_LATENCY(RL), .CURSOR_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wren(wren), .wr_row(wr_row), .wr_data(wr_data), .cursor(cursor),
    .rd_en(rd_en), .top_sel(top_sel), .out_ready(out_ready),
    .win_valid(win_valid), .win_cursor(win_cursor), .win_border(win_border),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren) begin
      wr_rows.push_back(int'(wr_row));
      wr_curs.push_back(int'(cursor));
      wr_datas.push_back(int'(wr_data));
      wr_cyc.push_back(cyc);
    end
    if (rd_en) begin
      rd_curs.push_back(int'(cursor));
      rd_cyc.push_back(cyc);
      rd_top.push_back(int'(top_sel));
    end
    if (win_valid) begin
      win_curs.push_back(int'(win_cursor));
      win_cyc.push_back(cyc);
      win_bord.push_back(int'(win_border));
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_rows.delete(); wr_curs.delete(); wr_datas.delete(); wr_cyc.delete();
    rd_curs.delete(); rd_cyc.delete(); rd_top.delete();
    win_curs.delete(); win_cyc.delete(); win_bord.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Sends n pixels first..first+n-1; pix_valid stays high while the DUT is busy.
  task automatic send_pixels(input int first, input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      pix_valid = 1'b1;
      pix_data  = 16'(first + sent);
      if (pix_ready) sent++;
      step();
      guard++;
    end
    pix_valid = 1'b0;
    checks++;
    if (sent !== n) begin
      errors++;
      $display("FAIL send_pixels sent %0d required %0d", sent, n);
    end
  endtask

  task automatic wait_rd(input int c);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rd_en && int'(cursor) == c) ok = 1'b1;
      else step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_rd timeout cursor %0d", c);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pix_ready, wren, wr_row, wr_data, cursor, rd_en, top_sel, win_valid, win_cursor, win_border, frame_done}
        !== {1'b0, 1'b0, 3'b001, 16'h0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got pix_ready=%0b wren=%0b wr_row=%0b cursor=%0d win_valid=%0b required idle with wr_row=001",
               pix_ready, wren, wr_row, cursor, win_valid);
    end
  endtask

  task automatic test_first_rows();
    do_reset();
    start_frame();
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL fill_pix_ready got %0b required 1", pix_ready); end
    send_pixels(0, 24);
    repeat (25) step();
    checks++;
    if (wr_curs.size() !== 24) begin errors++; $display("FAIL fill_wren_count got %0d required 24", wr_curs.size()); end
    for (int i = 0; i < 24 && i < wr_curs.size(); i++) begin
      checks++;
      if (wr_rows[i] !== (1 << (i / 8)) || wr_curs[i] !== (i % 8) || wr_datas[i] !== i) begin
        errors++;
        $display("FAIL fill_write[%0d] got row=%0d cur=%0d data=%0d required row=%0d cur=%0d data=%0d",
                 i, wr_rows[i], wr_curs[i], wr_datas[i], 1 << (i / 8), i % 8, i);
      end
    end
    checks++;
    if (rd_curs.size() !== WPR || win_curs.size() !== WPR) begin
      errors++;
      $display("FAIL sweep_counts got rd=%0d win=%0d required %0d", rd_curs.size(), win_curs.size(), WPR);
    end
    for (int i = 0; i < WPR && i < rd_curs.size() && i < win_curs.size(); i++) begin
      checks++;
      if (rd_curs[i] !== FIRST_C + i || win_curs[i] !== FIRST_C + i || rd_top[i] !== 0 ||
          win_bord[i] !== int'(BORDER && (win_curs[i] == 0 || win_curs[i] == BL - 1))) begin
        errors++;
        $display("FAIL sweep_window[%0d] got rd_cur=%0d win_cur=%0d top=%0d border=%0d required cur=%0d top=0",
                 i, rd_curs[i], win_curs[i], rd_top[i], win_bord[i], FIRST_C + i);
      end
    end
    if (rd_cyc.size() > 0 && win_cyc.size() > 0) begin
      checks++;
      if (win_cyc[0] - rd_cyc[0] !== RL) begin
        errors++;
        $display("FAIL win_latency got %0d required %0d", win_cyc[0] - rd_cyc[0], RL);
      end
    end
    checks++;
    if (wr_row !== 3'b001 || done_cnt !== 0) begin
      errors++;
      $display("FAIL post_sweep got wr_row=%0b done=%0d required 001 and 0", wr_row, done_cnt);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    start_frame();
    send_pixels(0, 40);
    for (int i = 0; i < 300 && done_cnt == 0; i++) step();
    repeat (5) step();
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL frame_done_count got %0d required 1", done_cnt); end
    checks++;
    if (wr_curs.size() !== 40 || win_curs.size() !== 3 * WPR) begin
      errors++;
      $display("FAIL frame_counts got wren=%0d win=%0d required 40 and %0d", wr_curs.size(), win_curs.size(), 3 * WPR);
    end
    for (int i = 0; i < 40 && i < wr_curs.size(); i++) begin
      checks++;
      if (wr_rows[i] !== (1 << ((i / 8) % 3)) || wr_curs[i] !== (i % 8) || wr_datas[i] !== i) begin
        errors++;
        $display("FAIL frame_write[%0d] got row=%0d cur=%0d data=%0d required row=%0d cur=%0d",
                 i, wr_rows[i], wr_curs[i], wr_datas[i], 1 << ((i / 8) % 3), i % 8);
      end
    end
    for (int k = 0; k < 3 && k * WPR < rd_top.size(); k++) begin
      checks++;
      if (rd_top[k * WPR] !== k) begin
        errors++;
        $display("FAIL sweep_top_sel[%0d] got %0d required %0d", k, rd_top[k * WPR], k);
      end
    end
    if (win_cyc.size() > 0) begin
      checks++;
      if (done_cyc - win_cyc[win_cyc.size() - 1] !== 2) begin
        errors++;
        $display("FAIL frame_done_timing got %0d required 2", done_cyc - win_cyc[win_cyc.size() - 1]);
      end
    end
    pix_valid = 1'b1;
    repeat (3) step();
    checks++;
    if (pix_ready !== 1'b0 || wren !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_frame got pix_ready=%0b wren=%0b required 0", pix_ready, wren);
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    start_frame();
    send_pixels(0, 24);
    wait_rd(3);
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    repeat (20) step();
    checks++;
    if (rd_curs.size() !== WPR || win_curs.size() !== WPR) begin
      errors++;
      $display("FAIL stall_counts got rd=%0d win=%0d required %0d", rd_curs.size(), win_curs.size(), WPR);
    end
    for (int i = 0; i < WPR && i < win_curs.size(); i++) begin
      checks++;
      if (win_curs[i] !== FIRST_C + i) begin
        errors++;
        $display("FAIL stall_window[%0d] got %0d required %0d", i, win_curs[i], FIRST_C + i);
      end
    end
    if (rd_cyc.size() > 4 - FIRST_C) begin
      checks++;
      if (rd_cyc[4 - FIRST_C] - rd_cyc[3 - FIRST_C] !== 5) begin
        errors++;
        $display("FAIL stall_gap got %0d required 5", rd_cyc[4 - FIRST_C] - rd_cyc[3 - FIRST_C]);
      end
    end
  endtask

  task automatic test_hold_valid();
    int guard = 0;
    do_reset();
    start_frame();
    send_pixels(0, 24);
    pix_valid = 1'b1;
    pix_data  = 16'hABCD;
    while (wr_curs.size() < 25 && guard < 100) begin
      if (rd_en) begin
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL sweep_pix_ready got %0b required 0", pix_ready); end
      end
      step();
      guard++;
    end
    pix_valid = 1'b0;
    checks++;
    if (wr_curs.size() !== 25 || win_curs.size() !== WPR) begin
      errors++;
      $display("FAIL hold_counts got wren=%0d win=%0d required 25 and %0d", wr_curs.size(), win_curs.size(), WPR);
    end else begin
      checks++;
      if (wr_curs[24] !== 0 || wr_rows[24] !== 1 || wr_datas[24] !== 16'hABCD || wr_cyc[24] <= win_cyc[WPR - 1]) begin
        errors++;
        $display("FAIL hold_next_write got cur=%0d row=%0d data=%0h cyc=%0d required cur=0 row=1 data=abcd after cyc %0d",
                 wr_curs[24], wr_rows[24], wr_datas[24], wr_cyc[24], win_cyc[WPR - 1]);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    start_frame();
    send_pixels(0, 24);
    wait_rd(5);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || wr_row !== 3'b001 || cursor !== '0 || rd_en !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_sweep got win_valid=%0b wr_row=%0b cursor=%0d rd_en=%0b pix_ready=%0b required 0 001 0 0 1",
               win_valid, wr_row, cursor, rd_en, pix_ready);
    end
    clear_logs();
    repeat (10) step();
    checks++;
    if (win_curs.size() !== 0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_quiet got win=%0d done=%0d required 0 and 0", win_curs.size(), done_cnt);
    end
    send_pixels(0, 13);
    pix_valid   = 1'b1;
    pix_data    = 16'hDEAD;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    checks++;
    if (wr_row !== 3'b001 || cursor !== '0 || wren !== 1'b0) begin
      errors++;
      $display("FAIL abort_fill got wr_row=%0b cursor=%0d wren=%0b required 001 0 0", wr_row, cursor, wren);
    end
    repeat (3) step();
    checks++;
    if (wr_datas.size() !== 13 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_dropped_pixel got writes=%0d done=%0d required 13 and 0", wr_datas.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    start_frame();
    send_pixels(0, 24);
    wait_rd(3);
    reset = 1'b1;
    #1;
    checks++;
    if ({pix_ready, wren, wr_row, wr_data, cursor, rd_en, top_sel, win_valid, win_cursor, win_border, frame_done}
        !== {1'b0, 1'b0, 3'b001, 16'h0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_sweep got wr_data=%0d cursor=%0d rd_en=%0b win_valid=%0b wr_row=%0b required zeros and 001",
               wr_data, cursor, rd_en, win_valid, wr_row);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
    done_cnt = 0; done_cyc = 0;
    test_reset();
    test_first_rows();
    test_full_frame();
    test_stall();
    test_hold_valid();
    test_abort();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
